// File: rtl/ledarray_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ledarray_pkg
// Brief    : Shared state encodings and frame constants for the LED-array path.
// Revision : 1.0 - initial release
// ============================================================================
package ledarray_pkg;

  typedef enum logic [1:0] {
    BIT_IDLE  = 2'd0,
    BIT_START = 2'd1,
    BIT_DATA  = 2'd2,
    BIT_STOP  = 2'd3
  } bit_state_e;

  typedef enum logic [0:0] {
    FR_WAIT_SYNC = 1'b0,
    FR_COLLECT   = 1'b1
  } frame_state_e;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         FRAME_LEN = 16;

endpackage
`default_nettype wire

// File: rtl/uart_rx_byte.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_byte
// Brief    : 2-FF RX synchroniser plus 8N1 bit-level receive state machine.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_byte
  import ledarray_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       rx_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_data_o,
  output logic       frame_err_o
);

  localparam int               CNT_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic             sync1_q;
  logic             rxs_q;
  bit_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;
  logic             valid_q;
  logic [7:0]       data_q;
  logic             ferr_q;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
      state_q <= BIT_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= rx_i;
      rxs_q   <= sync1_q;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      case (state_q)
        BIT_IDLE: begin
          if (!rxs_q) begin
            state_q <= BIT_START;
            cnt_q   <= '0;
          end
        end
        BIT_START: begin
          // A line that is high again at mid-start-bit was only a glitch.
          if (cnt_q == CNT_MID) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= rxs_q ? BIT_IDLE : BIT_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        BIT_DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            shift_q <= {rxs_q, shift_q[7:1]};
            bit_q   <= bit_q + 1'b1;
            if (bit_q == 3'd7) begin
              state_q <= BIT_STOP;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        BIT_STOP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            state_q <= BIT_IDLE;
            if (rxs_q) begin
              valid_q <= 1'b1;
              data_q  <= shift_q;
            end else begin
              ferr_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= BIT_IDLE;
      endcase
    end
  end

  assign byte_valid_o = valid_q;
  assign byte_data_o  = data_q;
  assign frame_err_o  = ferr_q;

endmodule
`default_nettype wire

// File: rtl/uart_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_frame_rx
// Brief    : UART byte receiver plus sync-headed 16-byte frame assembler with an
//            atomically updated display buffer.
// Revision : 1.0 - initial release
// ============================================================================
module uart_frame_rx
  import ledarray_pkg::*;
#(
  parameter int         CLK_HZ    = 12_000_000,
  parameter int         BAUD      = 115200,
  parameter logic [7:0] SYNC_BYTE = ledarray_pkg::SYNC_BYTE,
  parameter int         GAP_BITS  = 20
) (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic       RX,
  input  logic [3:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_ready,
  output logic       frame_busy,
  output logic       rx_err
);

  localparam int               CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int               GAP_CYCLES   = GAP_BITS * CLKS_PER_BIT;
  localparam int               GAP_W        = $clog2(GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LAST     = GAP_W'(GAP_CYCLES - 1);
  localparam logic [3:0]       IDX_LAST     = 4'(FRAME_LEN - 1);

  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ferr;
  logic       gap_timeout;

  frame_state_e     frame_q;
  logic [3:0]       idx_q;
  logic [GAP_W-1:0] gap_q;
  logic [7:0]       shadow_q [FRAME_LEN];
  logic [7:0]       disp_q   [FRAME_LEN];
  logic [7:0]       rd_data_q;
  logic             frame_ready_q;
  logic             rx_err_q;

  uart_rx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx_byte (
    .clk_i        (CLK),
    .rstn_i       (RSTN),
    .rx_i         (RX),
    .byte_valid_o (rx_valid),
    .byte_data_o  (rx_data),
    .frame_err_o  (rx_ferr)
  );

  assign gap_timeout = (frame_q == FR_COLLECT) && !rx_valid && (gap_q == GAP_LAST);

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      frame_q       <= FR_WAIT_SYNC;
      idx_q         <= '0;
      gap_q         <= '0;
      rd_data_q     <= '0;
      frame_ready_q <= 1'b0;
      rx_err_q      <= 1'b0;
      for (int i = 0; i < FRAME_LEN; i++) begin
        shadow_q[i] <= '0;
        disp_q[i]   <= '0;
      end
    end else begin
      frame_ready_q <= 1'b0;
      // Framing error and timeout are ORed so a coincidence yields one pulse.
      rx_err_q      <= rx_ferr | gap_timeout;
      rd_data_q     <= disp_q[rd_addr];
      case (frame_q)
        FR_WAIT_SYNC: begin
          gap_q <= '0;
          if (rx_valid && (rx_data == SYNC_BYTE)) begin
            frame_q <= FR_COLLECT;
            idx_q   <= '0;
          end
        end
        FR_COLLECT: begin
          if (rx_ferr || gap_timeout) begin
            frame_q <= FR_WAIT_SYNC;
            gap_q   <= '0;
          end else if (rx_valid) begin
            gap_q           <= '0;
            shadow_q[idx_q] <= rx_data;
            idx_q           <= idx_q + 1'b1;
            if (idx_q == IDX_LAST) begin
              // The final byte bypasses shadow so disp is whole on frame_ready.
              for (int i = 0; i < FRAME_LEN; i++) begin
                disp_q[i] <= shadow_q[i];
              end
              disp_q[IDX_LAST] <= rx_data;
              frame_ready_q    <= 1'b1;
              frame_q          <= FR_WAIT_SYNC;
            end
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        default: frame_q <= FR_WAIT_SYNC;
      endcase
    end
  end

  assign rd_data     = rd_data_q;
  assign byte_valid  = rx_valid;
  assign byte_data   = rx_data;
  assign frame_ready = frame_ready_q;
  assign frame_busy  = (frame_q == FR_COLLECT);
  assign rx_err      = rx_err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_frame_rx
// Brief    : Directed self-checking bench for uart_frame_rx at 10 clocks per bit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_frame_rx;

  logic       CLK  = 1'b0;
  logic       RSTN = 1'b0;
  logic       RX   = 1'b1;
  logic [3:0] rd_addr = 4'd0;
  logic [7:0] rd_data;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       frame_ready;
  logic       frame_busy;
  logic       rx_err;

  int checks = 0;
  int errors = 0;

  int cyc = 0, bv_cnt = 0, fr_cnt = 0, err_cnt = 0, busy_cnt = 0;
  int last_bv_cyc = 0, fr_cyc = 0, err_cyc = 0;

  uart_frame_rx #(
    .CLK_HZ (1_000_000),
    .BAUD   (100_000)
  ) dut (
    .CLK         (CLK),
    .RSTN        (RSTN),
    .RX          (RX),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .frame_ready (frame_ready),
    .frame_busy  (frame_busy),
    .rx_err      (rx_err)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    cyc = cyc + 1;
    if (byte_valid) begin
      bv_cnt      = bv_cnt + 1;
      last_bv_cyc = cyc;
    end
    if (frame_ready) begin
      fr_cnt = fr_cnt + 1;
      fr_cyc = cyc;
    end
    if (rx_err) begin
      err_cnt = err_cnt + 1;
      err_cyc = cyc;
    end
    if (frame_busy) busy_cnt = busy_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    RX = 1'b0;
    wait_cycles(10);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      wait_cycles(10);
    end
    RX = stop_bit;
    wait_cycles(10);
    RX = 1'b1;
  endtask

  task automatic read_addr(input logic [3:0] a, output logic [7:0] d);
    rd_addr = a;
    wait_cycles(1);
    d = rd_data;
  endtask

  initial begin
    logic [7:0] d;
    int b0, f0, e0, busy0;

    wait_cycles(4);
    RSTN = 1'b1;
    wait_cycles(2);
    check("reset_outs", {23'd0, byte_valid, frame_ready, rx_err, frame_busy, byte_data}, 32'd0);
    for (int a = 0; a < 16; a++) begin
      read_addr(4'(a), d);
      check("reset_disp", {24'd0, d}, 32'h00);
    end

    // Frame 1: sync then 00..0F back to back.
    b0 = bv_cnt; f0 = fr_cnt;
    send_byte(8'hA5, 1'b1);
    for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b1);
    wait_cycles(20);
    check("f1_byte_valids", bv_cnt - b0, 17);
    check("f1_frame_ready", fr_cnt - f0, 1);
    check("f1_ready_timing", fr_cyc, last_bv_cyc + 1);
    check("f1_last_byte", {24'd0, byte_data}, 32'h0F);
    check("f1_busy_after", {31'd0, frame_busy}, 0);
    read_addr(4'd3, d);
    check("f1_addr3", {24'd0, d}, 32'h03);
    read_addr(4'd15, d);
    check("f1_addr15", {24'd0, d}, 32'h0F);

    // Non-sync bytes ignored, then an all-A5 frame.
    b0 = bv_cnt; busy0 = busy_cnt; f0 = fr_cnt;
    send_byte(8'h3C, 1'b1);
    send_byte(8'h7E, 1'b1);
    wait_cycles(5);
    check("nosync_bytes", bv_cnt - b0, 2);
    check("nosync_busy", busy_cnt - busy0, 0);
    send_byte(8'hA5, 1'b1);
    for (int i = 0; i < 16; i++) send_byte(8'hA5, 1'b1);
    wait_cycles(20);
    check("f2_frame_ready", fr_cnt - f0, 1);
    check("f2_busy_seen", {31'd0, (busy_cnt > busy0)}, 1);
    for (int a = 0; a < 16; a++) begin
      read_addr(4'(a), d);
      check("f2_disp", {24'd0, d}, 32'hA5);
    end

    // Gap timeout in the middle of a frame.
    e0 = err_cnt; f0 = fr_cnt;
    send_byte(8'hA5, 1'b1);
    for (int i = 1; i <= 5; i++) send_byte(8'(i * 17), 1'b1);
    wait_cycles(300);
    check("gap_err_count", err_cnt - e0, 1);
    check("gap_err_timing", {31'd0, ((err_cyc - last_bv_cyc) >= 199) && ((err_cyc - last_bv_cyc) <= 202)}, 1);
    check("gap_no_ready", fr_cnt - f0, 0);
    check("gap_busy", {31'd0, frame_busy}, 0);
    read_addr(4'd0, d);
    check("gap_disp0", {24'd0, d}, 32'hA5);
    read_addr(4'd9, d);
    check("gap_disp9", {24'd0, d}, 32'hA5);

    // Framing error mid-frame, then a good frame.
    e0 = err_cnt; b0 = bv_cnt;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h5A, 1'b0);
    wait_cycles(30);
    check("ferr_err_count", err_cnt - e0, 1);
    check("ferr_byte_valids", bv_cnt - b0, 4);
    check("ferr_busy", {31'd0, frame_busy}, 0);
    f0 = fr_cnt;
    send_byte(8'hA5, 1'b1);
    for (int i = 0; i < 16; i++) send_byte(8'(i * 17), 1'b1);
    wait_cycles(20);
    check("f3_frame_ready", fr_cnt - f0, 1);
    read_addr(4'd0, d);
    check("f3_addr0", {24'd0, d}, 32'h00);
    read_addr(4'd5, d);
    check("f3_addr5", {24'd0, d}, 32'h55);
    read_addr(4'd15, d);
    check("f3_addr15", {24'd0, d}, 32'hFF);

    // Short low glitch must be rejected silently.
    b0 = bv_cnt; e0 = err_cnt;
    RX = 1'b0;
    wait_cycles(3);
    RX = 1'b1;
    wait_cycles(40);
    check("glitch_no_byte", bv_cnt - b0, 0);
    check("glitch_no_err", err_cnt - e0, 0);

    // Reset in the middle of a frame.
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    check("mid_busy", {31'd0, frame_busy}, 1);
    RSTN = 1'b0;
    wait_cycles(1);
    check("rst_busy", {31'd0, frame_busy}, 0);
    wait_cycles(2);
    RSTN = 1'b1;
    wait_cycles(2);
    read_addr(4'd15, d);
    check("rst_disp15", {24'd0, d}, 32'h00);
    read_addr(4'd5, d);
    check("rst_disp5", {24'd0, d}, 32'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
